// File: rtl/gmii_rx_frame_monitor.sv
// GMII receive frame monitor: delimits frames on rx_dv and reports
// per-frame length, first octet, sum, error/oversize and counters.
module gmii_rx_frame_monitor #(
  parameter int OCTET_WIDTH = 8,
  parameter int LEN_WIDTH   = 12,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   mr_main_reset,
  input  logic [OCTET_WIDTH-1:0] rxd,
  input  logic                   rx_dv,
  input  logic                   rx_er,
  output logic                   frame_done,
  output logic [LEN_WIDTH-1:0]   frame_len,
  output logic [OCTET_WIDTH-1:0] first_octet,
  output logic [OCTET_WIDTH-1:0] frame_sum,
  output logic                   frame_err,
  output logic                   frame_ovf,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic                   false_carrier
);

  typedef enum logic {
    IDLE,
    IN_FRAME
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LEN_WIDTH-1:0] OVF_LIM = LEN_WIDTH'(MAX_LEN);
  localparam logic [OCTET_WIDTH-1:0] FC_CODE = OCTET_WIDTH'(8'h0E);

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   acc_len_q, acc_len_d;
  logic [OCTET_WIDTH-1:0] acc_sum_q, acc_sum_d;
  logic [OCTET_WIDTH-1:0] acc_first_q, acc_first_d;
  logic                   acc_err_q, acc_err_d;
  logic                   done_q, done_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [OCTET_WIDTH-1:0] first_q, first_d;
  logic [OCTET_WIDTH-1:0] sum_q, sum_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]   ecnt_q, ecnt_d;
  logic                   fc_q, fc_d;
  logic                   ovf_now;

  // State, accumulators and result registers
  always_ff @(posedge clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q     <= IDLE;
      acc_len_q   <= '0;
      acc_sum_q   <= '0;
      acc_first_q <= '0;
      acc_err_q   <= 1'b0;
      done_q      <= 1'b0;
      len_q       <= '0;
      first_q     <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      fcnt_q      <= '0;
      ecnt_q      <= '0;
      fc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_len_q   <= acc_len_d;
      acc_sum_q   <= acc_sum_d;
      acc_first_q <= acc_first_d;
      acc_err_q   <= acc_err_d;
      done_q      <= done_d;
      len_q       <= len_d;
      first_q     <= first_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      fcnt_q      <= fcnt_d;
      ecnt_q      <= ecnt_d;
      fc_q        <= fc_d;
    end
  end

  assign ovf_now = (acc_len_q > OVF_LIM);

  // Next-state: frame delimiting, accumulation and result capture
  always_comb begin
    state_d     = state_q;
    acc_len_d   = acc_len_q;
    acc_sum_d   = acc_sum_q;
    acc_first_d = acc_first_q;
    acc_err_d   = acc_err_q;
    done_d      = 1'b0;
    len_d       = len_q;
    first_d     = first_q;
    sum_d       = sum_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    fcnt_d      = fcnt_q;
    ecnt_d      = ecnt_q;
    fc_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_dv) begin
          state_d     = IN_FRAME;
          acc_len_d   = LEN_WIDTH'(1);
          acc_sum_d   = rxd;
          acc_first_d = rxd;
          acc_err_d   = rx_er;
        end else if (rx_er && (rxd == FC_CODE)) begin
          fc_d = 1'b1;
        end
      end
      IN_FRAME: begin
        if (rx_dv) begin
          if (acc_len_q != LEN_MAX) begin
            acc_len_d = acc_len_q + LEN_WIDTH'(1);
          end
          acc_sum_d = acc_sum_q + rxd;
          acc_err_d = acc_err_q | rx_er;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          len_d   = acc_len_q;
          first_d = acc_first_q;
          sum_d   = acc_sum_q;
          err_d   = acc_err_q;
          ovf_d   = ovf_now;
          if (fcnt_q != CNT_MAX) begin
            fcnt_d = fcnt_q + CNT_WIDTH'(1);
          end
          if ((acc_err_q || ovf_now) && (ecnt_q != CNT_MAX)) begin
            ecnt_d = ecnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_done    = done_q;
  assign frame_len     = len_q;
  assign first_octet   = first_q;
  assign frame_sum     = sum_q;
  assign frame_err     = err_q;
  assign frame_ovf     = ovf_q;
  assign frame_count   = fcnt_q;
  assign err_count     = ecnt_q;
  assign false_carrier = fc_q;

endmodule

// File: tb/tb_gmii_rx_frame_monitor.sv
// Scoreboard bench for gmii_rx_frame_monitor (MAX_LEN=16).
// Stimulus pushes expected results; a monitor pops on frame_done.
module tb_gmii_rx_frame_monitor;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [11:0] len;
    logic [7:0]  first;
    logic [7:0]  sum;
    logic        err;
    logic        ovf;
    logic [15:0] fcnt;
    logic [15:0] ecnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic        frame_done;
  logic [11:0] frame_len;
  logic [7:0]  first_octet;
  logic [7:0]  frame_sum;
  logic        frame_err;
  logic        frame_ovf;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic        false_carrier;

  gmii_rx_frame_monitor #(
    .OCTET_WIDTH(8), .LEN_WIDTH(12),
    .CNT_WIDTH(16), .MAX_LEN(16)
  ) dut (
    .clk(clk), .mr_main_reset(rst),
    .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .frame_done(frame_done), .frame_len(frame_len),
    .first_octet(first_octet), .frame_sum(frame_sum),
    .frame_err(frame_err), .frame_ovf(frame_ovf),
    .frame_count(frame_count), .err_count(err_count),
    .false_carrier(false_carrier)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t last;
  int   checks = 0;
  int   passes = 0;
  int   fc_seen = 0;
  int   fc_exp = 0;
  int   mfc = 0;
  int   mec = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Monitor: compare every frame_done against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 32'(frame_done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_len", 32'(frame_len), 32'(e.len));
          chk("first_octet", 32'(first_octet), 32'(e.first));
          chk("frame_sum", 32'(frame_sum), 32'(e.sum));
          chk("frame_err", 32'(frame_err), 32'(e.err));
          chk("frame_ovf", 32'(frame_ovf), 32'(e.ovf));
          chk("frame_count", 32'(frame_count), 32'(e.fcnt));
          chk("err_count", 32'(err_count), 32'(e.ecnt));
        end
      end
      if (false_carrier) fc_seen++;
    end
  end

  task automatic idle(input int n, input logic er,
                      input logic [7:0] d);
    for (int i = 0; i < n; i++) begin
      rx_dv = 1'b0; rx_er = er; rxd = d;
      @(posedge clk); #1;
    end
    rx_er = 1'b0; rxd = 8'h00;
  endtask

  task automatic send_frame(input bq_t d, input int erridx,
                            input logic [7:0] hsum);
    exp_t e;
    logic [7:0] s;
    s = 8'h00;
    foreach (d[i]) s = s + d[i];
    e.len   = 12'(d.size());
    e.first = d[0];
    e.sum   = hsum;
    e.err   = (erridx >= 0);
    e.ovf   = (d.size() > 16);
    mfc++;
    if (e.err || e.ovf) mec++;
    e.fcnt = 16'(mfc);
    e.ecnt = 16'(mec);
    chk("hand_sum", 32'(s), 32'(hsum));
    exp_q.push_back(e);
    last = e;
    foreach (d[i]) begin
      rx_dv = 1'b1; rxd = d[i]; rx_er = (i == erridx);
      @(posedge clk); #1;
    end
    idle(1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1; #3; rst = 1'b0;
    exp_q.delete();
    mfc = 0; mec = 0;
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"},
        {16'(frame_count | err_count), 12'(frame_len),
         4'({frame_done, frame_err, frame_ovf, false_carrier})}, 32'd0);
    chk({nm, "_data"}, 32'({first_octet, frame_sum}), 32'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  bq_t f4, big, b16, fa, fb, pre;

  initial begin
    f4  = '{8'h6B, 8'h37, 8'h87, 8'hAC};
    big = {}; b16 = {};
    for (int i = 1; i <= 20; i++) big.push_back(8'(i));
    for (int i = 1; i <= 16; i++) b16.push_back(8'(i));
    fa  = '{8'h10, 8'h20, 8'h30};
    fb  = '{8'hF0, 8'h20, 8'h01};
    pre = '{8'hAA, 8'hBB};

    #2;
    rst = 1'b1; #4;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(9, 1'b0, 8'h00);
    chk_zero("idle9");

    send_frame(f4, -1, 8'hD5);
    send_frame(f4, 1, 8'hD5);
    send_frame(big, -1, 8'hD2);
    send_frame(b16, -1, 8'h88);
    idle(2, 1'b0, 8'h00);
    drain();
    chk("err_count_after_ovf", 32'(err_count), 32'd2);

    fc_exp++;
    idle(1, 1'b1, 8'h0E);
    idle(2, 1'b0, 8'h00);
    idle(3, 1'b1, 8'h0F);
    idle(2, 1'b1, 8'h55);
    idle(2, 1'b0, 8'h00);
    chk("hold_len", 32'(frame_len), 32'(last.len));
    chk("hold_sum", 32'(frame_sum), 32'(last.sum));
    chk("hold_cnt", 32'(frame_count), 32'(last.fcnt));
    chk("false_carrier_pulses", 32'(fc_seen), 32'(fc_exp));

    foreach (pre[i]) begin
      rx_dv = 1'b1; rxd = pre[i];
      @(posedge clk); #1;
    end
    do_reset();
    idle(4, 1'b0, 8'h00);
    chk_zero("midframe_reset");

    send_frame(fa, -1, 8'h60);
    send_frame(fb, -1, 8'h11);
    idle(2, 1'b0, 8'h00);
    drain();
    chk("b2b_frame_count", 32'(frame_count), 32'd2);
    chk("fc_total", 32'(fc_seen), 32'(fc_exp));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1);
  end

endmodule
